determ_decoder: RTL and testbench

DETERM_DECODER -- requirements
Module: determ_decoder

---
 rtl/determ_decoder.sv | 121 ++++++++++++
 tb/tb_determ_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/determ_decoder.sv
// determ_decoder: decodes a deterministic bipolar bitstream (1 = +1, 0 = -1)
// into a signed frame sum over FRAME_LEN accepted bits.
// The result is held with a valid/ready handshake.
// Optional feature: define DETERM_DECODER_OVF_EN to add the sticky ovf output.
// ovf flags bits that arrive while a finished result is waiting to be taken.
// OUT_W must be at least clog2(FRAME_LEN+1)+1 so that +/-FRAME_LEN fits without wrap.
module determ_decoder #(
  parameter int FRAME_LEN = 256,
  parameter int OUT_W     = 10
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    start,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic signed [OUT_W-1:0] y,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    busy
`ifdef DETERM_DECODER_OVF_EN
  ,
  output logic                    ovf
`endif
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [OUT_W-1:0] PLUS_ONE  = OUT_W'(1);
  localparam logic signed [OUT_W-1:0] MINUS_ONE = {OUT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    state;
  logic signed [OUT_W-1:0]   acc;
  logic        [CNT_W-1:0]   cnt;

  // Map a bitstream bit onto its bipolar contribution.
  function automatic logic signed [OUT_W-1:0] bipolar_step(input logic b);
    return b ? PLUS_ONE : MINUS_ONE;
  endfunction

  // Frame FSM: accumulate accepted bits, then present and hold the sum.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef DETERM_DECODER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Bits arriving here are dropped silently.
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef DETERM_DECODER_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end

        ACCUM: begin
          // start is deliberately ignored mid-frame.
          if (bit_valid) begin
            acc <= acc + bipolar_step(bit_in);
            if (cnt == LAST_IDX) begin
              y       <= acc + bipolar_step(bit_in);
              y_valid <= 1'b1;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        HOLD: begin
`ifdef DETERM_DECODER_OVF_EN
          if (bit_valid) begin
            ovf <= 1'b1;
          end
`endif
          if (y_valid && y_ready) begin
            y_valid <= 1'b0;
            if (start) begin
              // Back-to-back frame: skip IDLE entirely.
              state <= ACCUM;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
`ifdef DETERM_DECODER_OVF_EN
              ovf   <= 1'b0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          y_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_determ_decoder.sv
// Directed testbench for determ_decoder (FRAME_LEN=256, OUT_W=10).
module tb_determ_decoder;

  localparam int FRAME_LEN = 256;
  localparam int OUT_W     = 10;

  logic                    CLK;
  logic                    nRST;
  logic                    start;
  logic                    bit_in;
  logic                    bit_valid;
  logic signed [OUT_W-1:0] y;
  logic                    y_valid;
  logic                    y_ready;
  logic                    busy;
`ifdef DETERM_DECODER_OVF_EN
  logic                    ovf;
`endif

  int checks = 0;
  int passes = 0;

  determ_decoder #(.FRAME_LEN(FRAME_LEN), .OUT_W(OUT_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .busy      (busy)
`ifdef DETERM_DECODER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit pattern for frame mode: 0 all ones, 1 all zeros, 2 alternating 1,0, 3 192 ones then 64 zeros
  function automatic logic pat(input int mode, input int idx);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return (idx % 2) == 0;
      default: return idx < 192;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake();
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
  endtask

  // Drive n valid bits of the pattern starting at index first; gap cycles drive bit_in=0 unqualified.
  task automatic send_bits(input int mode, input int first, input int n, input bit gaps);
    int sent = 0;
    int k = 0;
    while (sent < n) begin
      if (gaps && ((k % 4) == 1 || (k % 4) == 2)) begin
        bit_valid = 1'b0;
        bit_in    = 1'b0;
      end else begin
        bit_valid = 1'b1;
        bit_in    = pat(mode, first + sent);
        sent++;
      end
      tick();
      k++;
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick();
    tick();
    checks++; if (y !== 10'sd0) $display("FAIL reset_y actual=%0d required=0", y); else passes++;
    checks++; if (y_valid !== 1'b0) $display("FAIL reset_y_valid actual=%b required=0", y_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy); else passes++;
`ifdef DETERM_DECODER_OVF_EN
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf actual=%b required=0", ovf); else passes++;
`endif
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_idle_drop();
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    repeat (5) tick();
    bit_valid = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy actual=%b required=0", busy); else passes++;
    checks++; if (y_valid !== 1'b0) $display("FAIL idle_y_valid actual=%b required=0", y_valid); else passes++;
  endtask

  task automatic test_all_ones();
    do_start();
    checks++; if (busy !== 1'b1) $display("FAIL ones_busy_accum actual=%b required=1", busy); else passes++;
    send_bits(0, 0, FRAME_LEN - 1, 1'b0);
    checks++; if (y_valid !== 1'b0) $display("FAIL ones_early_valid actual=%b required=0", y_valid); else passes++;
    send_bits(0, FRAME_LEN - 1, 1, 1'b0);
    checks++; if (y_valid !== 1'b1) $display("FAIL ones_valid actual=%b required=1", y_valid); else passes++;
    checks++; if (y !== 10'sd256) $display("FAIL ones_y actual=%0d required=256", y); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL ones_busy_hold actual=%b required=1", busy); else passes++;
    handshake();
    checks++; if (y_valid !== 1'b0) $display("FAIL ones_valid_after_hs actual=%b required=0", y_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ones_busy_after_hs actual=%b required=0", busy); else passes++;
    checks++; if (y !== 10'sd256) $display("FAIL ones_y_retained actual=%0d required=256", y); else passes++;
  endtask

  task automatic test_patterns();
    do_start();
    send_bits(1, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== -10'sd256) $display("FAIL zeros_y actual=%0d/%b required=-256/1", y, y_valid); else passes++;
    handshake();
    do_start();
    send_bits(2, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd0) $display("FAIL alt_y actual=%0d/%b required=0/1", y, y_valid); else passes++;
    handshake();
    do_start();
    send_bits(3, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd128) $display("FAIL split_y actual=%0d/%b required=128/1", y, y_valid); else passes++;
    handshake();
  endtask

  task automatic test_gaps();
    do_start();
    send_bits(0, 0, FRAME_LEN, 1'b1);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd256) $display("FAIL gaps_y actual=%0d/%b required=256/1", y, y_valid); else passes++;
    handshake();
  endtask

  task automatic test_start_in_accum();
    do_start();
    send_bits(0, 0, 10, 1'b0);
    start = 1'b1;
    send_bits(0, 10, 1, 1'b0);
    start = 1'b0;
    send_bits(0, 11, FRAME_LEN - 11, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd256) $display("FAIL accum_start_y actual=%0d/%b required=256/1", y, y_valid); else passes++;
    handshake();
  endtask

  task automatic test_hold_stall();
    do_start();
    send_bits(0, 0, FRAME_LEN, 1'b0);
    y_ready   = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    start     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (y !== 10'sd256 || y_valid !== 1'b1) $display("FAIL hold_stable cyc=%0d actual=%0d/%b required=256/1", i, y, y_valid);
      else passes++;
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL hold_busy actual=%b required=1", busy); else passes++;
`ifdef DETERM_DECODER_OVF_EN
    checks++; if (ovf !== 1'b1) $display("FAIL hold_ovf actual=%b required=1", ovf); else passes++;
`endif
    handshake();
`ifdef DETERM_DECODER_OVF_EN
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky actual=%b required=1", ovf); else passes++;
`endif
    do_start();
`ifdef DETERM_DECODER_OVF_EN
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear actual=%b required=0", ovf); else passes++;
`endif
    send_bits(1, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== -10'sd256) $display("FAIL after_stall_y actual=%0d/%b required=-256/1", y, y_valid); else passes++;
    handshake();
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    send_bits(0, 0, 100, 1'b0);
    nRST      = 1'b0;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    y_ready   = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    y_ready   = 1'b0;
    checks++; if (y !== 10'sd0 || y_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_outputs actual=%0d/%b/%b required=0/0/0", y, y_valid, busy); else passes++;
    nRST = 1'b1;
    repeat (3) tick();
    checks++; if (y_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_idle actual=%b/%b required=0/0", y_valid, busy); else passes++;
    do_start();
    send_bits(0, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd256) $display("FAIL midreset_new_y actual=%0d/%b required=256/1", y, y_valid); else passes++;
    handshake();
  endtask

  task automatic test_back_to_back();
    do_start();
    send_bits(2, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd0) $display("FAIL b2b_first_y actual=%0d/%b required=0/1", y, y_valid); else passes++;
    y_ready = 1'b1;
    start   = 1'b1;
    tick();
    y_ready = 1'b0;
    start   = 1'b0;
    checks++; if (busy !== 1'b1 || y_valid !== 1'b0) $display("FAIL b2b_transition actual=%b/%b required=1/0", busy, y_valid); else passes++;
    send_bits(3, 0, FRAME_LEN, 1'b0);
    checks++; if (y_valid !== 1'b1 || y !== 10'sd128) $display("FAIL b2b_second_y actual=%0d/%b required=128/1", y, y_valid); else passes++;
    handshake();
  endtask

  initial begin
    nRST      = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    y_ready   = 1'b0;
    test_reset();
    test_idle_drop();
    test_all_ones();
    test_patterns();
    test_gaps();
    test_start_in_accum();
    test_hold_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
